// File: rtl/eret_pkg.sv
// eret_pkg: shared constants for the return-from-exception sequencer.
//   - SPR file indices touched by the ERET sequence
//   - ERET opcode / funct fields
//   - 3-bit sequencer state encoding
// Optional feature macro used by the sequencer: ERET_SYNC_EN.
package eret_pkg;

  // SPR file indices
  localparam logic [2:0] SPR_SR    = 3'd0;
  localparam logic [2:0] SPR_ESR   = 3'd1;
  localparam logic [2:0] SPR_EPC   = 3'd3;
  localparam logic [2:0] SPR_EMODE = 3'd6;
  localparam logic [2:0] SPR_MODE  = 3'd7;

  // ERET encoding: opcode in [31:26], funct in [5:0]
  localparam logic [5:0] ERET_OPCODE = 6'b010000;
  localparam logic [5:0] ERET_FUNCT  = 6'b011000;

  // Sequencer states. All eight codes are used, so no illegal encoding
  // exists; ST_WAIT is only reachable in the ERET_SYNC_EN build.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_RD_EPC   = 3'd2,
    ST_RD_ESR   = 3'd3,
    ST_WR_SR    = 3'd4,
    ST_RD_EMODE = 3'd5,
    ST_WR_MODE  = 3'd6,
    ST_DONE     = 3'd7
  } eret_state_e;

  // True when the word carries the ERET opcode and funct, ignoring valid.
  function automatic logic is_eret_word(input logic [31:0] insn);
    return (insn[31:26] == ERET_OPCODE) && (insn[5:0] == ERET_FUNCT);
  endfunction

endpackage

// File: rtl/eret_decode.sv
// eret_decode: combinational ERET recogniser.
//   instruction  in   instruction word
//   valid        in   instruction is valid this cycle
//   mode_in      in   current MODE register value
//   is_eret      out  valid ERET present
//   is_ill       out  valid ERET issued from user mode
// Also consumed by the interrupt path as an illegal-instruction cause.
import eret_pkg::*;

module eret_decode #(
  parameter int          DATA_W    = 32,
  parameter int unsigned USER_MODE = 1
) (
  input  logic [31:0]       instruction,
  input  logic              valid,
  input  logic [DATA_W-1:0] mode_in,
  output logic              is_eret,
  output logic              is_ill
);

  // The middle of the word carries no ERET information.
  logic unused_mid;
  assign unused_mid = ^instruction[25:6];

  assign is_eret = valid & is_eret_word(instruction);
  assign is_ill  = is_eret & (mode_in == DATA_W'(USER_MODE));

endmodule

// File: rtl/eret_unit.sv
// eret_unit: return-from-exception sequencer.
// Undoes the interrupt entry path: reads EPC, restores SR from ESR and
// MODE from EMODE through the shared single-port SPR file, then redirects
// the PC to EPC. The pipeline is stalled for the whole sequence.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   instruction   execute-stage instruction word
//   valid         instruction valid
//   mode_in       current MODE value
//   jisr          interrupt taken this cycle (aborts / blocks the sequence)
//   pipe_empty    older instructions retired (ERET_SYNC_EN build only)
//   spr_rdata     combinational SPR read data for spr_sel
//   spr_sel       SPR index
//   spr_wdata     SPR write data
//   spr_we        SPR write strobe
//   stall, busy   sequence in progress
//   pc_redirect   one-cycle strobe to load redirect_pc
//   redirect_pc   restored PC, held until the next completed sequence
//   eret_ill      one-cycle strobe: ERET attempted in user mode
//
// Macro ERET_SYNC_EN: when defined, a legal ERET first waits in ST_WAIT
// until pipe_empty before touching the SPR file. When undefined the wait
// state is never entered and pipe_empty is ignored.
import eret_pkg::*;

module eret_unit #(
  parameter int          DATA_W    = 32,
  parameter int          SEL_W     = 3,
  parameter int unsigned USER_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              valid,
  input  logic [DATA_W-1:0] mode_in,
  input  logic              jisr,
  input  logic              pipe_empty,
  input  logic [DATA_W-1:0] spr_rdata,
  output logic [SEL_W-1:0]  spr_sel,
  output logic [DATA_W-1:0] spr_wdata,
  output logic              spr_we,
  output logic              stall,
  output logic              busy,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              eret_ill
);

  eret_state_e       state_q, state_d;
  logic [DATA_W-1:0] epc_q, esr_q, emode_q, redirect_q;
  logic              is_eret, is_ill, accept;
  logic              we_raw, redirect_raw;
  logic [2:0]        sel_idx;

`ifndef ERET_SYNC_EN
  logic unused_pipe_empty;
  assign unused_pipe_empty = pipe_empty;
`endif

  eret_decode #(
    .DATA_W    (DATA_W),
    .USER_MODE (USER_MODE)
  ) u_decode (
    .instruction (instruction),
    .valid       (valid),
    .mode_in     (mode_in),
    .is_eret     (is_eret),
    .is_ill      (is_ill)
  );

  // An interrupt in the same cycle wins over a new ERET.
  assign accept = is_eret & ~is_ill & ~jisr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
`ifdef ERET_SYNC_EN
        if (accept) state_d = ST_WAIT;
`else
        if (accept) state_d = ST_RD_EPC;
`endif
      end
      ST_WAIT: begin
`ifdef ERET_SYNC_EN
        if (pipe_empty) state_d = ST_RD_EPC;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RD_EPC:   state_d = ST_RD_ESR;
      ST_RD_ESR:   state_d = ST_WR_SR;
      ST_WR_SR:    state_d = ST_RD_EMODE;
      ST_RD_EMODE: state_d = ST_WR_MODE;
      ST_WR_MODE:  state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Interrupt abort; writes already committed stay in the SPR file.
    if (jisr) state_d = ST_IDLE;
  end

  // State-decoded outputs (before interrupt/reset gating)
  always_comb begin
    sel_idx      = SPR_SR;
    spr_wdata    = '0;
    we_raw       = 1'b0;
    redirect_raw = 1'b0;
    unique case (state_q)
      ST_RD_EPC:   sel_idx = SPR_EPC;
      ST_RD_ESR:   sel_idx = SPR_ESR;
      ST_WR_SR: begin
        sel_idx   = SPR_SR;
        spr_wdata = esr_q;
        we_raw    = 1'b1;
      end
      ST_RD_EMODE: sel_idx = SPR_EMODE;
      ST_WR_MODE: begin
        sel_idx   = SPR_MODE;
        spr_wdata = emode_q;
        we_raw    = 1'b1;
      end
      ST_DONE:     redirect_raw = 1'b1;
      default:     sel_idx = SPR_SR;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign stall       = busy;
  assign spr_sel     = SEL_W'(sel_idx);
  // No SPR write and no redirect in a cycle that is being aborted.
  assign spr_we      = we_raw & ~jisr & ~rst;
  assign pc_redirect = redirect_raw & ~jisr & ~rst;
  // Show the fresh EPC in the DONE cycle; otherwise hold the last one.
  assign redirect_pc = redirect_raw ? epc_q : redirect_q;
  assign eret_ill    = (state_q == ST_IDLE) & is_ill & ~jisr & ~rst;

  // Read latches and held redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q      <= '0;
      esr_q      <= '0;
      emode_q    <= '0;
      redirect_q <= '0;
    end else begin
      if (state_q == ST_RD_EPC)   epc_q   <= spr_rdata;
      if (state_q == ST_RD_ESR)   esr_q   <= spr_rdata;
      if (state_q == ST_RD_EMODE) emode_q <= spr_rdata;
      if (pc_redirect)            redirect_q <= epc_q;
    end
  end

endmodule

// File: tb/tb_eret_unit.sv
// Self-checking bench for eret_unit: directed cases with literal
// expectations followed by randomized traffic, all compared every cycle
// against a sequence-level model of the ERET operation list.
module tb_eret_unit;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;
`ifdef ERET_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam int WOFF = SYNC ? 1 : 0;
  localparam logic [31:0] ERET_W = 32'h4000_0018;
  localparam logic [31:0] NEAR_W = 32'h4000_0000;

  logic              clk = 1'b0;
  logic              rst, valid, jisr, pipe_empty;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] mode_in, spr_rdata, spr_wdata, redirect_pc;
  logic [SEL_W-1:0]  spr_sel;
  logic              spr_we, stall, busy, pc_redirect, eret_ill;

  // Environment SPR file (written by the DUT) and the model's copy
  logic [DATA_W-1:0] spr_file [8];
  logic [DATA_W-1:0] exp_spr  [8];
  assign spr_rdata = spr_file[spr_sel];

  int errs = 0;
  int checks = 0;

  // Model: position in the six-step operation list (0 = idle)
  int                m_step = 0;
  bit                m_wait = 1'b0;
  logic [DATA_W-1:0] m_epc = '0, m_esr = '0, m_emode = '0, m_last_pc = '0;

  always #5 clk = ~clk;

  eret_unit #(.DATA_W(DATA_W), .SEL_W(SEL_W), .USER_MODE(1)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .valid(valid),
    .mode_in(mode_in), .jisr(jisr), .pipe_empty(pipe_empty),
    .spr_rdata(spr_rdata), .spr_sel(spr_sel), .spr_wdata(spr_wdata),
    .spr_we(spr_we), .stall(stall), .busy(busy), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .eret_ill(eret_ill)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // SPR index used by each step of the ERET operation list
  function automatic logic [2:0] sel_of(input int s);
    case (s)
      1: return 3'd3;   // read EPC
      2: return 3'd1;   // read ESR
      3: return 3'd0;   // write SR
      4: return 3'd6;   // read EMODE
      5: return 3'd7;   // write MODE
      default: return 3'd0;
    endcase
  endfunction

  // Compare every cycle at negedge; advance model at posedge
  initial begin : cmp
    logic              busy_e, we_e, red_e, ill_e, is_er, ill_in;
    logic [2:0]        sel_e;
    logic [DATA_W-1:0] wd_e, rpc_e;
    logic              rst_s, jisr_s, pe_s, we_s;
    logic [2:0]        sel_s;
    logic [DATA_W-1:0] wd_s;
    forever begin
      @(negedge clk);
      is_er  = valid && (instruction[31:26] == 6'b010000) && (instruction[5:0] == 6'b011000);
      ill_in = is_er && (mode_in == 32'd1);
      busy_e = (m_step != 0) || m_wait;
      sel_e  = m_wait ? 3'd0 : sel_of(m_step);
      we_e   = ((m_step == 3) || (m_step == 5)) && !jisr && !rst;
      wd_e   = (m_step == 3) ? m_esr : (m_step == 5) ? m_emode : '0;
      red_e  = (m_step == 6) && !jisr && !rst;
      rpc_e  = (m_step == 6) ? m_epc : m_last_pc;
      ill_e  = !busy_e && ill_in && !jisr && !rst;
      chk("busy",        32'(busy),        32'(busy_e));
      chk("stall",       32'(stall),       32'(busy_e));
      chk("spr_sel",     32'(spr_sel),     32'(sel_e));
      chk("spr_we",      32'(spr_we),      32'(we_e));
      chk("spr_wdata",   spr_wdata,        wd_e);
      chk("pc_redirect", 32'(pc_redirect), 32'(red_e));
      chk("redirect_pc", redirect_pc,      rpc_e);
      chk("eret_ill",    32'(eret_ill),    32'(ill_e));
      chk("spr_sr",      spr_file[0],      exp_spr[0]);
      chk("spr_mode",    spr_file[7],      exp_spr[7]);
      rst_s = rst; jisr_s = jisr; pe_s = pipe_empty;
      we_s = spr_we; sel_s = spr_sel; wd_s = spr_wdata;
      @(posedge clk);
      if (we_s) spr_file[sel_s] = wd_s;
      if (rst_s) begin
        m_step = 0; m_wait = 1'b0; m_last_pc = '0;
        m_epc = '0; m_esr = '0; m_emode = '0;
      end else if (busy_e && jisr_s) begin
        m_step = 0; m_wait = 1'b0;
      end else if (m_wait) begin
        if (pe_s) begin m_wait = 1'b0; m_step = 1; end
      end else begin
        case (m_step)
          0: if (is_er && !ill_in && !jisr_s) begin
               if (SYNC) m_wait = 1'b1; else m_step = 1;
             end
          1: begin m_epc   = exp_spr[3]; m_step = 2; end
          2: begin m_esr   = exp_spr[1]; m_step = 3; end
          3: begin exp_spr[0] = m_esr;   m_step = 4; end
          4: begin m_emode = exp_spr[6]; m_step = 5; end
          5: begin exp_spr[7] = m_emode; m_step = 6; end
          default: begin m_last_pc = m_epc; m_step = 0; end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spr(input int idx, input logic [DATA_W-1:0] v);
    spr_file[idx] = v;
    exp_spr[idx]  = v;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; jisr = 1'b0; rst = 1'b0; instruction = NEAR_W; mode_in = '0;
  endtask

  initial begin : stim
    int lat, stall_cnt, we_n, r, hits;
    logic [2:0] we_sel [2];
    logic [DATA_W-1:0] we_dat [2];
    logic [DATA_W-1:0] rpc_at;
    for (int i = 0; i < 8; i++) set_spr(i, '0);
    rst = 1'b1; valid = 1'b0; jisr = 1'b0; pipe_empty = 1'b0;
    instruction = '0; mode_in = '0;
    tick(); tick();
    idle_inputs();
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_spr_we", 32'(spr_we), 32'd0);

    // Legal ERET: EPC=0x100, ESR=0xFF, EMODE=1; pipe_empty low for 4 cycles
    set_spr(1, 32'h0000_00FF); set_spr(3, 32'h0000_0100); set_spr(6, 32'd1);
    instruction = ERET_W; valid = 1'b1; mode_in = '0; pipe_empty = 1'b0;
    lat = 0; stall_cnt = 0; we_n = 0; rpc_at = '0;
    we_sel[0] = '0; we_sel[1] = '0; we_dat[0] = '0; we_dat[1] = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      valid = 1'b0;
      if (k == 4) pipe_empty = 1'b1;
      #1;
      if (stall) stall_cnt++;
      if (spr_we && we_n < 2) begin we_sel[we_n] = spr_sel; we_dat[we_n] = spr_wdata; we_n++; end
      if (pc_redirect && lat == 0) begin lat = k; rpc_at = redirect_pc; end
    end
    chk("legal_latency", 32'(lat), SYNC ? 32'd10 : 32'd6);
    chk("legal_redirect_pc", rpc_at, 32'h0000_0100);
    chk("legal_stall_cycles", 32'(stall_cnt), SYNC ? 32'd10 : 32'd6);
    chk("legal_write_count", 32'(we_n), 32'd2);
    chk("legal_first_write_sel", 32'(we_sel[0]), 32'd0);
    chk("legal_first_write_data", we_dat[0], 32'h0000_00FF);
    chk("legal_second_write_sel", 32'(we_sel[1]), 32'd7);
    chk("legal_second_write_data", we_dat[1], 32'd1);
    chk("legal_sr_value", spr_file[0], 32'h0000_00FF);
    chk("legal_mode_value", spr_file[7], 32'd1);
    chk("legal_pc_held", redirect_pc, 32'h0000_0100);

    // ERET from user mode
    pipe_empty = 1'b1;
    instruction = ERET_W; valid = 1'b1; mode_in = 32'd1;
    #1;
    chk("ill_pulse", 32'(eret_ill), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    hits = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(); valid = 1'b0; #1;
      hits += int'(spr_we) + int'(pc_redirect) + int'(busy) + int'(eret_ill);
    end
    chk("ill_no_activity", 32'(hits), 32'd0);

    // jisr in WR_SR
    set_spr(0, 32'h0000_00A5); set_spr(1, 32'h0000_0077);
    instruction = ERET_W; valid = 1'b1; mode_in = '0;
    for (int k = 1; k <= 3 + WOFF; k++) begin tick(); valid = 1'b0; end
    jisr = 1'b1; #1;
    chk("jisr_state_is_wr_sr", 32'(spr_sel), 32'd0);
    chk("jisr_we_blocked", 32'(spr_we), 32'd0);
    tick(); jisr = 1'b0; #1;
    chk("jisr_idle_next", 32'(busy), 32'd0);
    hits = 0;
    for (int k = 0; k < 6; k++) begin tick(); #1; hits += int'(pc_redirect); end
    chk("jisr_no_redirect", 32'(hits), 32'd0);
    chk("jisr_sr_unchanged", spr_file[0], 32'h0000_00A5);

    // rst in RD_EMODE
    set_spr(0, '0); set_spr(7, 32'h0000_0033); set_spr(1, 32'h0000_005A);
    instruction = ERET_W; valid = 1'b1; mode_in = '0;
    for (int k = 1; k <= 4 + WOFF; k++) begin tick(); valid = 1'b0; end
    rst = 1'b1; #1;
    chk("rst_in_rd_emode", 32'(spr_sel), 32'd6);
    tick(); rst = 1'b0; #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_spr_sel", 32'(spr_sel), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_sr_restored", spr_file[0], 32'h0000_005A);
    chk("rst_mode_unchanged", spr_file[7], 32'h0000_0033);

    // Near-miss opcode and ERET without valid
    instruction = NEAR_W; valid = 1'b1;
    tick(); valid = 1'b0; #1;
    chk("near_miss_idle", 32'(busy), 32'd0);
    instruction = ERET_W; valid = 1'b0;
    tick(); #1;
    chk("invalid_eret_idle", 32'(busy), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (m_step == 0 && !m_wait && ($urandom % 4 == 0)) begin
        set_spr(1, $urandom); set_spr(3, $urandom); set_spr(6, $urandom);
      end
      rst   = ($urandom % 150 == 0);
      jisr  = ($urandom % 25 == 0);
      valid = $urandom % 2 == 0;
      r = int'($urandom % 4);
      instruction = (r < 2) ? ERET_W : (r == 2) ? NEAR_W : 32'($urandom);
      r = int'($urandom % 8);
      mode_in = (r == 0) ? 32'd1 : (r == 1) ? 32'($urandom) : 32'd0;
      pipe_empty = ($urandom % 3 != 0);
    end
    idle_inputs();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
